// File: rtl/carfield_uart_line_monitor.sv
// UART 8N1 line monitor: 2-flop synchroniser, receive FSM, byte FIFO with a
// valid/ready output, newline counter, framing-error pulse and sticky overflow.
module carfield_uart_line_monitor #(
    parameter int unsigned ClksPerBit   = 1736,
    parameter int unsigned FifoDepth    = 16,
    parameter int unsigned LineCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rx_i,
    output logic [7:0]              byte_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    line_done_o,
    output logic [LineCntWidth-1:0] line_cnt_o,
    output logic                    frame_err_o,
    output logic                    overflow_o,
    input  logic                    clear_i
);

    localparam int unsigned CntW  = $clog2(ClksPerBit);
    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam logic [CntW-1:0]         HalfLoad = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0]         FullLoad = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0]         CntOne   = CntW'(1);
    localparam logic [AddrW:0]          PtrOne   = (AddrW + 1)'(1);
    localparam logic [LineCntWidth-1:0] LineOne  = LineCntWidth'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic            rx_meta;
    logic            rx_s;
    state_t          state;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;

    logic [7:0]      mem [FifoDepth];
    logic [AddrW:0]  wptr;
    logic [AddrW:0]  rptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            accept;
    logic            is_newline;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM: cnt is a down-counter, a sample is taken when it reaches zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= HalfLoad;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state <= ST_DATA;
                            cnt   <= FullLoad;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FullLoad;
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO status, push/pop qualification and head-of-FIFO output
    always_comb begin
        push         = (state == ST_STOP) && (cnt == '0) && rx_s;
        empty        = (wptr == rptr);
        full         = (wptr[AddrW] != rptr[AddrW]) &&
                       (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
        pop          = !empty && byte_ready_i;
        accept       = push && (!full || pop);
        is_newline   = (shreg == 8'h0A);
        byte_valid_o = !empty;
        byte_o       = empty ? '0 : mem[rptr[AddrW-1:0]];
    end

    // FIFO pointers with one wrap bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + PtrOne;
            end
            if (pop) begin
                rptr <= rptr + PtrOne;
            end
        end
    end

    // FIFO storage; contents are only observable through the pointers
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wptr[AddrW-1:0]] <= shreg;
        end
    end

    // Newline pulse/counter and sticky overflow; clear wins over same-cycle updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_done_o <= 1'b0;
            line_cnt_o  <= '0;
            overflow_o  <= 1'b0;
        end else begin
            line_done_o <= accept && is_newline;
            if (clear_i) begin
                line_cnt_o <= '0;
                overflow_o <= 1'b0;
            end else begin
                if (accept && is_newline) begin
                    line_cnt_o <= line_cnt_o + LineOne;
                end
                if (push && !accept) begin
                    overflow_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_carfield_uart_line_monitor.sv
// Self-checking bench for carfield_uart_line_monitor: directed scenarios plus
// randomized frames, compared every cycle against a transaction-level model.
module tb_carfield_uart_line_monitor;

    localparam int C = 16;
    localparam int H = C / 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        line_done;
    logic [15:0] line_cnt;
    logic        frame_err;
    logic        overflow;
    logic        clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_mode = 1'b0;

    carfield_uart_line_monitor #(
        .ClksPerBit  (C),
        .FifoDepth   (D),
        .LineCntWidth(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .byte_o      (byte_o),
        .byte_valid_o(byte_valid),
        .byte_ready_i(byte_ready),
        .line_done_o (line_done),
        .line_cnt_o  (line_cnt),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .clear_i     (clear)
    );

    always #5 clk = ~clk;

    // Model: a frame whose line falls before edge n has its stop bit judged at
    // edge n + 2 (synchroniser) + H (to mid start bit) + 9*C.
    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  m_q[$];
    bit          m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;
    bit          m_ld = 1'b0;
    bit          m_fe = 1'b0;

    logic [7:0]  popped[$];
    int          fe_seen = 0;
    int          ld_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, advanced once per clock edge
    always @(posedge clk) begin
        bit   pop, push, was_full, ovf_set, inc;
        ev_t  e;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            evq.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
            m_ld  = 1'b0;
            m_fe  = 1'b0;
        end else begin
            m_ld = 1'b0;
            m_fe = 1'b0;
            push = 1'b0;
            ovf_set = 1'b0;
            inc = 1'b0;
            e = '{at: 0, data: 8'h00, ok: 1'b0};
            if (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.ok) push = 1'b1;
                else m_fe = 1'b1;
            end
            was_full = (m_q.size() == D);
            pop = (m_q.size() > 0) && byte_ready;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (was_full && !pop) begin
                    ovf_set = 1'b1;
                end else begin
                    m_q.push_back(e.data);
                    if (e.data == 8'h0A) begin
                        m_ld = 1'b1;
                        inc = 1'b1;
                    end
                end
            end
            if (clear) begin
                m_ovf = 1'b0;
                m_cnt = '0;
            end else begin
                if (ovf_set) m_ovf = 1'b1;
                if (inc) m_cnt = m_cnt + 16'd1;
            end
        end
    end

    // Compare DUT against the model on every out-of-reset cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", {31'd0, byte_valid}, {31'd0, m_q.size() > 0});
            check("byte", {24'd0, byte_o}, {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
            check("line_done", {31'd0, line_done}, {31'd0, m_ld});
            check("line_cnt", {16'd0, line_cnt}, {16'd0, m_cnt});
            check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (byte_valid === 1'b1 && byte_ready === 1'b1) popped.push_back(byte_o);
            if (frame_err === 1'b1) fe_seen++;
            if (line_done === 1'b1) ld_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input bit ok, input int stop_cycles);
        evq.push_back('{at: cyc + 1 + 2 + H + 9 * C, data: d, ok: ok});
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(C);
        end
        rx = ok;
        idle(stop_cycles);
        rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte"}, {24'd0, byte_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
        check({tag, "_line_done"}, {31'd0, line_done}, 32'd0);
        check({tag, "_line_cnt"}, {16'd0, line_cnt}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    // Expected bytes packed little-endian in exp (byte i at exp[8*i +: 8])
    task automatic check_popped(input string name, input int n, input logic [31:0] exp);
        logic [7:0] want;
        check({name, "_count"}, popped.size(), n);
        for (int i = 0; i < n && i < popped.size(); i++) begin
            want = exp[8 * i +: 8];
            check({name, "_data"}, {24'd0, popped[i]}, {24'd0, want});
        end
        popped.delete();
    endtask

    // Random ready/clear driver for the randomized phase
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rnd_mode) begin
                byte_ready = ($urandom_range(0, 2) != 0);
                clear      = ($urandom_range(0, 40) == 0);
            end
        end
    end

    // Watchdog
    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int p;
        int fe0;
        logic [7:0] d;
        bit ok;

        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        // 1: single byte, valid exactly one cycle after the stop-bit sample
        byte_ready = 1'b1;
        p = cyc + 1 + 2 + H + 9 * C;
        fork
            send(8'h41, 1'b1, C);
            begin
                wait (cyc == p - 1);
                @(negedge clk);
                check("t1_valid_before", {31'd0, byte_valid}, 32'd0);
                wait (cyc == p);
                @(negedge clk);
                check("t1_valid_after", {31'd0, byte_valid}, 32'd1);
                check("t1_byte", {24'd0, byte_o}, 32'h41);
            end
        join
        idle(C);
        check_popped("t1", 1, 32'h41);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_frame_err", fe_seen, 0);

        // 2: "ok\n"
        send(8'h6F, 1'b1, C);
        send(8'h6B, 1'b1, C);
        send(8'h0A, 1'b1, C);
        idle(C);
        check_popped("t2", 3, 32'h000A6B6F);
        check("t2_line_done_pulses", ld_seen, 1);
        check("t2_line_cnt", {16'd0, line_cnt}, 32'd1);

        // 3: short low glitch on idle line
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(3 * C);
        check_popped("t3", 0, 32'd0);
        check("t3_frame_err", fe_seen, 0);

        // 4: break after 0x55, then a good byte
        fe0 = fe_seen;
        send(8'h55, 1'b0, 40 * C);
        idle(2 * C);
        check("t4_frame_err_pulses", fe_seen - fe0, 1);
        check_popped("t4_break", 0, 32'd0);
        send(8'h12, 1'b1, C);
        idle(C);
        check_popped("t4_recover", 1, 32'h12);

        // 5: overflow with ready low, drain, clear
        byte_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, C);
        idle(C);
        check("t5_overflow", {31'd0, overflow}, 32'd1);
        check("t5_head", {24'd0, byte_o}, 32'h01);
        byte_ready = 1'b1;
        idle(10);
        check_popped("t5_drain", 4, 32'h04030201);
        check("t5_overflow_held", {31'd0, overflow}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
        check("t5_line_cnt_cleared", {16'd0, line_cnt}, 32'd0);

        // 6: reset during data bit 3 with a newline parked in the FIFO
        byte_ready = 1'b0;
        send(8'h0A, 1'b1, C);
        idle(C);
        check("t6_pre_valid", {31'd0, byte_valid}, 32'd1);
        check("t6_pre_line_cnt", {16'd0, line_cnt}, 32'd1);
        d = 8'h7E;
        evq.push_back('{at: cyc + 1 + 2 + H + 9 * C, data: d, ok: 1'b1});
        rx = 1'b0;
        idle(C);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            idle(C);
        end
        rx = d[3];
        idle(H);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        idle(3);
        rst_n = 1'b1;
        idle(2 * C);
        check_popped("t6_aborted", 0, 32'd0);
        byte_ready = 1'b1;
        send(8'h7E, 1'b1, C);
        idle(C);
        check_popped("t6_resend", 1, 32'h7E);

        // Randomized frames with random ready/clear and occasional bad stop bits
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d  = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send(d, ok, ok ? C : C * $urandom_range(1, 3));
            idle($urandom_range(H, 2 * C));
        end
        rnd_mode = 1'b0;
        clear = 1'b0;
        byte_ready = 1'b1;
        idle(2 * D + 4);
        check("end_fifo_empty", {31'd0, byte_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
